// File: rtl/min_max_scan_controller.sv
// Scan controller for the min/max search datapath: owns the element array and
// walks a wrapping window through one shared magnitude comparator.
module min_max_scan_controller #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Wr_En,
   input  logic [AW-1:0] Wr_Addr,
   input  logic [DW-1:0] Wr_Data,
   input  logic          Start,
   input  logic [AW-1:0] First,
   input  logic [AW:0]   Count,
   output logic          Busy,
   output logic          Done,
   output logic          Err,
   output logic [DW-1:0] Max,
   output logic [DW-1:0] Min,
   output logic [AW-1:0] Max_Idx,
   output logic [AW-1:0] Min_Idx,
   output logic          Qi,
   output logic          Ql,
   output logic          Qcmx,
   output logic          Qcmn,
   output logic          Qd
);

   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
   localparam logic [AW:0] REM_ONE = (AW+1)'(1);

   typedef enum logic [4:0] {
      INI  = 5'b00001,
      LOAD = 5'b00010,
      CMX  = 5'b00100,
      CMN  = 5'b01000,
      DONE = 5'b10000
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   rem_q, rem_d;
   logic [DW-1:0] max_q, max_d;
   logic [DW-1:0] min_q, min_d;
   logic [AW-1:0] max_idx_q, max_idx_d;
   logic [AW-1:0] min_idx_q, min_idx_d;
   logic          err_q, err_d;
   logic          mem_we;

   logic [DW-1:0] mem_q [2**AW];

   logic [DW-1:0] elem;
   logic [DW-1:0] cmp_ref;
   logic          elem_gt;
   logic          elem_lt;
   logic          count_ok;

   // One comparator: the reference operand switches between Max and Min.
   assign elem     = mem_q[ptr_q];
   assign cmp_ref  = (state_q == CMN) ? min_q : max_q;
   assign elem_gt  = elem > cmp_ref;
   assign elem_lt  = elem < cmp_ref;
   assign count_ok = (Count != '0) && (Count <= DEPTH);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      max_d     = max_q;
      min_d     = min_q;
      max_idx_d = max_idx_q;
      min_idx_d = min_idx_q;
      err_d     = err_q;
      mem_we    = 1'b0;
      case (state_q)
         INI: begin
            mem_we = Wr_En;
            if (Start) begin
               if (count_ok) begin
                  ptr_d   = First;
                  rem_d   = Count;
                  state_d = LOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         LOAD: begin
            max_d     = elem;
            min_d     = elem;
            max_idx_d = ptr_q;
            min_idx_d = ptr_q;
            ptr_d     = ptr_q + AW'(1);
            rem_d     = rem_q - REM_ONE;
            state_d   = (rem_q == REM_ONE) ? DONE : CMX;
         end
         CMX: begin
            // A new maximum cannot also be a new minimum, so CMN is skipped.
            if (elem_gt) begin
               max_d     = elem;
               max_idx_d = ptr_q;
               ptr_d     = ptr_q + AW'(1);
               rem_d     = rem_q - REM_ONE;
               state_d   = (rem_q == REM_ONE) ? DONE : CMX;
            end else begin
               state_d = CMN;
            end
         end
         CMN: begin
            if (elem_lt) begin
               min_d     = elem;
               min_idx_d = ptr_q;
            end
            ptr_d   = ptr_q + AW'(1);
            rem_d   = rem_q - REM_ONE;
            state_d = (rem_q == REM_ONE) ? DONE : CMX;
         end
         DONE: begin
            err_d   = 1'b0;
            state_d = INI;
         end
         default: state_d = INI;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= INI;
         ptr_q     <= '0;
         rem_q     <= '0;
         max_q     <= '0;
         min_q     <= '0;
         max_idx_q <= '0;
         min_idx_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         max_q     <= max_d;
         min_q     <= min_d;
         max_idx_q <= max_idx_d;
         min_idx_q <= min_idx_d;
         err_q     <= err_d;
      end
   end

   // Array contents survive reset.
   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem_q[Wr_Addr] <= Wr_Data;
      end
   end

   assign Busy    = (state_q != INI);
   assign Done    = (state_q == DONE);
   assign Err     = err_q;
   assign Max     = max_q;
   assign Min     = min_q;
   assign Max_Idx = max_idx_q;
   assign Min_Idx = min_idx_q;
   assign Qi      = (state_q == INI);
   assign Ql      = (state_q == LOAD);
   assign Qcmx    = (state_q == CMX);
   assign Qcmn    = (state_q == CMN);
   assign Qd      = (state_q == DONE);

endmodule
